// File: rtl/onehot_decoder_buf_if.sv
// Valid/ready handshake bundle for the one-hot decoder buffer: a binary code
// going in and a decoded one-hot word coming out.
interface onehot_decoder_buf_if #(
  parameter int unsigned WIDTH = 2
);
  localparam int unsigned OUT_W = 1 << WIDTH;

  logic [WIDTH-1:0] s;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] y;
  logic             out_valid;
  logic             out_ready;

  // master: code producer and word consumer; slave: the decoder buffer
  modport master (
    output s,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  y,
    input  out_valid
  );

  modport slave (
    input  s,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output y,
    output out_valid
  );
endinterface

// File: rtl/onehot_decoder_buf.sv
// Binary-to-one-hot decoder feeding a 2-entry FIFO, with a free-running
// delivered-word counter. Absorbs consumer back-pressure.
module onehot_decoder_buf #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  onehot_decoder_buf_if.slave     bus,
  output logic [CNT_W-1:0]        count
);
  localparam int unsigned OUT_W = 1 << WIDTH;

  logic [OUT_W-1:0] mem_q [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       occ_q;
  logic [CNT_W-1:0] count_q;

  logic             full;
  logic             push;
  logic             pop;
  logic [OUT_W-1:0] dec;

  // in_ready depends only on local state, en and rst_n; never on out_ready
  assign full          = (occ_q == 2'd2);
  assign bus.in_ready  = en & ~full & rst_n;
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.y         = bus.out_valid ? mem_q[rd_ptr_q] : '0;
  assign count         = count_q;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_comb begin
    dec        = '0;
    dec[bus.s] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= dec;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        count_q  <= count_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end
endmodule

// File: tb/tb_onehot_decoder_buf.sv
// Directed self-checking bench for onehot_decoder_buf (counter narrowed to
// 3 bits so wrap-around is reachable quickly).
module tb_onehot_decoder_buf;
  localparam int unsigned WIDTH = 2;
  localparam int unsigned CNT_W = 3;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  onehot_decoder_buf_if #(.WIDTH(WIDTH)) bus ();

  onehot_decoder_buf #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .bus  (bus),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; bus.s = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.y !== 4'b0000) begin n_fail++;
      $display("FAIL reset_y: got %b want 0000", bus.y); end
    n_checks++; if (count !== 3'd0) begin n_fail++;
      $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++;
      $display("FAIL reset_in_ready_low: got %b want 0", bus.in_ready); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_in_ready_after: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single_decode();
    logic [3:0] exp_y [4];
    exp_y[0] = 4'b0001; exp_y[1] = 4'b0010; exp_y[2] = 4'b0100; exp_y[3] = 4'b1000;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.s = 2'(i);
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.y !== exp_y[i]) begin n_fail++;
        $display("FAIL decode_y[%0d]: got v=%b y=%b want v=1 y=%b", i, bus.out_valid, bus.y,
                 exp_y[i]); end
      n_checks++; if (count !== 3'(i)) begin n_fail++;
        $display("FAIL decode_count[%0d]: got %0d want %0d", i, count, i); end
    end
    bus.in_valid = 1'b0;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0 || count !== 3'd4) begin n_fail++;
      $display("FAIL decode_final: got v=%b count=%0d want v=0 count=4", bus.out_valid, count);
    end
  endtask

  task automatic test_reset_mid();
    // one more delivery brings count to 5, then fill without draining
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.s = 2'd2;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.s = 2'd1;
    tick();
    bus.s = 2'd3;
    tick();
    bus.in_valid = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0 || count !== 3'd5 || bus.y !== 4'b0010) begin
      n_fail++;
      $display("FAIL midrst_full: got rdy=%b count=%0d y=%b want rdy=0 count=5 y=0010",
               bus.in_ready, count, bus.y); end
    rst_n = 1'b0;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0 || bus.y !== 4'b0000 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL midrst_state: got v=%b y=%b count=%0d want v=0 y=0000 count=0",
               bus.out_valid, bus.y, count); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++;
      $display("FAIL midrst_in_ready_low: got %b want 0", bus.in_ready); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL midrst_in_ready_after: got %b want 1", bus.in_ready); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL midrst_no_survivor: got v=%b want 0", bus.out_valid); end
  endtask

  task automatic test_back_pressure();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.s = 2'd3;
    tick();
    n_checks++; if (bus.y !== 4'b1000 || bus.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL bp_first: got y=%b rdy=%b want y=1000 rdy=1", bus.y, bus.in_ready); end
    bus.s = 2'd1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b0 || bus.y !== 4'b1000) begin n_fail++;
      $display("FAIL bp_full: got rdy=%b y=%b want rdy=0 y=1000", bus.in_ready, bus.y); end
    tick();
    n_checks++; if (bus.y !== 4'b1000 || bus.out_valid !== 1'b1) begin n_fail++;
      $display("FAIL bp_hold: got v=%b y=%b want v=1 y=1000", bus.out_valid, bus.y); end
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.y !== 4'b0010 || bus.in_ready !== 1'b1 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL bp_pop1: got y=%b rdy=%b count=%0d want y=0010 rdy=1 count=1",
               bus.y, bus.in_ready, count); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0 || count !== 3'd2) begin n_fail++;
      $display("FAIL bp_pop2: got v=%b count=%0d want v=0 count=2", bus.out_valid, count); end
  endtask

  task automatic test_simultaneous();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.s = 2'd0;
    tick();
    n_checks++; if (bus.y !== 4'b0001) begin n_fail++;
      $display("FAIL sim_head: got y=%b want 0001", bus.y); end
    bus.s = 2'd2; bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.y !== 4'b0100 || bus.out_valid !== 1'b1 || count !== 3'd3) begin
      n_fail++;
      $display("FAIL sim_advance: got v=%b y=%b count=%0d want v=1 y=0100 count=3",
               bus.out_valid, bus.y, count); end
    // occupancy 1 means one more push fills the FIFO
    bus.out_ready = 1'b0; bus.s = 2'd3;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b0 || bus.y !== 4'b0100) begin n_fail++;
      $display("FAIL sim_occ: got rdy=%b y=%b want rdy=0 y=0100", bus.in_ready, bus.y); end
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.y !== 4'b1000 || count !== 3'd4) begin n_fail++;
      $display("FAIL sim_drain1: got y=%b count=%0d want y=1000 count=4", bus.y, count); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0 || count !== 3'd5) begin n_fail++;
      $display("FAIL sim_drain2: got v=%b count=%0d want v=0 count=5", bus.out_valid, count);
    end
  endtask

  task automatic test_enable();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.s = 2'd1;
    tick();
    en = 1'b0; bus.s = 2'd3;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++;
      $display("FAIL en_gate: got rdy=%b want 0", bus.in_ready); end
    tick();
    n_checks++; if (bus.y !== 4'b0010) begin n_fail++;
      $display("FAIL en_hold: got y=%b want 0010", bus.y); end
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0 || count !== 3'd6) begin n_fail++;
      $display("FAIL en_drain: got v=%b count=%0d want v=0 count=6", bus.out_valid, count); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0 || count !== 3'd6) begin n_fail++;
      $display("FAIL en_no_push: got v=%b count=%0d want v=0 count=6", bus.out_valid, count);
    end
    bus.in_valid = 1'b0; en = 1'b1;
  endtask

  task automatic test_counter_wrap();
    logic [3:0] exp_y [4];
    exp_y[0] = 4'b0001; exp_y[1] = 4'b0010; exp_y[2] = 4'b0100; exp_y[3] = 4'b1000;
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    tick();
    rst_n = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.s = 2'(i % 4);
      tick();
      n_checks++; if (bus.y !== exp_y[i % 4] || count !== 3'(i % 8)) begin n_fail++;
        $display("FAIL wrap_step[%0d]: got y=%b count=%0d want y=%b count=%0d", i, bus.y,
                 count, exp_y[i % 4], i % 8); end
    end
    bus.in_valid = 1'b0;
    tick();
    n_checks++; if (count !== 3'd1 || bus.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL wrap_final: got count=%0d v=%b want count=1 v=0", count, bus.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_decode();
    test_reset_mid();
    test_back_pressure();
    test_simultaneous();
    test_enable();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/onehot_decoder_buf.md
Name: onehot_decoder_buf

Overview:
- Binary-to-one-hot decoder, the receive-side counterpart of the team's 4x2 priority encoder.
- Takes a WIDTH-bit binary code through a valid/ready input handshake and decodes it to a 2^WIDTH-bit one-hot word.
- Buffers decoded words in a 2-entry FIFO and presents them on a valid/ready output.
- Sits between encoded command sources and per-line enable logic, absorbing consumer back-pressure.

Parameters:
- WIDTH, 2, code width; output width OUT_W = 2^WIDTH (default 4).
- CNT_W, 8, width of the delivered-word counter.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- en  input  1  decoder enable; gates acceptance only.
- s  input  WIDTH  binary code to decode.
- in_valid  input  1  s is valid this cycle.
- in_ready  output  1  block accepts s this cycle.
- y  output  OUT_W  one-hot decoded word at the FIFO head.
- out_valid  output  1  y is valid.
- out_ready  input  1  consumer accepts y this cycle.
- count  output  CNT_W  number of words delivered, modulo 2^CNT_W.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - FIFO empties; out_valid=0, y=0, count=0.
  - in_ready=0 during any cycle in which rst_n=0.
  - Reset mid-transfer drops all buffered words; no partial word survives.
- Acceptance rules:
  - in_ready = en & !full & rst_n.
  - in_ready has no combinational path from out_ready or in_valid.
  - Push occurs when in_valid & in_ready at the clock edge.
- Decode rule: the entry stored is the one-hot word with bit s set and all other bits 0, e.g. s=2'b10 gives 4'b0100. Every code value is legal.
- Storage: 2-entry FIFO with read pointer, write pointer and occupancy (0..2). Pointers wrap 1->0.
- Output rules:
  - out_valid = (occupancy != 0).
  - y = head entry when out_valid=1, else all zeros. y is never non-one-hot.
- Pop occurs when out_valid & out_ready at the clock edge.
- Latency: a word accepted at edge N into an empty FIFO has out_valid=1 and y valid after edge N, i.e. 1 cycle.
- Throughput: 1 word/cycle sustained when out_ready=1.
- Simultaneous push and pop:
  - At occupancy 1: occupancy stays 1; the head advances to the new word.
  - At occupancy 2: in_ready=0, so only the pop occurs; in_ready=1 next cycle if en=1.
  - At occupancy 0: no pop is possible, so only the push occurs.
- Ordering: strict FIFO; no drop and no duplication.
- Stability: while out_valid=1 and out_ready=0, y holds its value.
- en=0:
  - in_ready=0 immediately, same cycle.
  - Buffered words still drain normally.
  - en has no effect on count.
- Counter:
  - count increments by 1 on every pop.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
  - count is registered and updates on the pop edge.
- Unknowns: in_valid=1 with X on s is out of contract. The bench does not drive it.

Test Plan:
- Single decode: after reset, drive out_ready=1 and s=0,1,2,3 with in_valid=1 in consecutive cycles. Required: y=0001,0010,0100,1000 one cycle later each, out_valid=1 on 4 consecutive cycles, count=4.
- Back-pressure fill: hold out_ready=0 and push s=3 then s=1. Required: in_ready=0 after the 2nd push, y held at 1000. Then raise out_ready. Required: y=1000 then 0010, and in_ready returns to 1 the cycle after the first pop.
- Simultaneous push/pop: at occupancy 1 (head 0001), push s=2 with out_ready=1. Required: occupancy stays 1, next y=0100, no word lost.
- Enable gating: load one word (s=1) with out_ready=0, then set en=0 and in_valid=1 with s=3. Required: in_ready=0, s=3 never appears, buffered 0010 drains once out_ready=1.
- Reset mid-operation: with FIFO full and count=5, assert rst_n=0 for one edge. Required: out_valid=0, y=0, count=0, in_ready=0 during reset and 1 after it (en=1).
- Counter wrap (CNT_W=3): deliver 9 words. Required: count sequence ends ...7,0,1.
